ram_arb: RTL
============

# ram_arb

Two-master arbiter for the SoC data RAM (2^RAM_AW × DW, single port, synchronous read). Shares the RAM between the Yduck core (master 0, priority) and a debug/loader port (master 1) that preloads and inspects memory while the core runs. Fixed priority to the core, with a bounded-wait age counter that guarantees master 1 a slot after MAX_WAIT consecutive losses. Sits between the core's load/store path and the RAM macro inside SoC.

## Interface
- DW, 16, data width
- RAM_AW, 7, RAM word-address width
- MAX_WAIT, 4, consecutive denied cycles before master 1 is forced through (1..15)

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- m0_req / m1_req  in  1  access request, held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  RAM_AW  word address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid, one-cycle pulse
- m0_rdata / m1_rdata  out  DW  read data; 0 when rvalid low
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid one cycle after ram_en with ram_we=0

## Operation
- Requester drives req, we, addr, wdata and holds them stable until gnt=1 in the same cycle; the transfer completes on that edge.
- At most one gnt per cycle; gnt only while the corresponding req=1.
- Grant rule: only m0_req → m0; only m1_req → m1; both → m0 unless age == MAX_WAIT, then m1.
- age (4-bit): +1 each cycle m1_req=1 and m1 not granted, saturating at MAX_WAIT; cleared to 0 when m1 granted or m1_req=0.
- Granted master's we/addr/wdata are muxed straight to ram_*; ram_en = m0_gnt | m1_gnt. With no grant, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Read grant: registers rd_pend=1 and rd_owner. Next cycle the owner's rvalid=1 and its rdata = ram_rdata; the other master's rdata=0.
- Write grant: no rvalid.
- A new grant is allowed in the cycle rvalid is high (back-to-back reads, one per cycle).

## Timing
- Reset values: age=0, rd_pend=0, rd_owner=0; all gnt, rvalid, ram_en, ram_we = 0; all rdata, ram_addr, ram_wdata = 0.
- Grant latency: 0 cycles when uncontended. Read latency: rvalid exactly 1 cycle after gnt.
- Worst-case m1 wait under continuous m0 traffic: MAX_WAIT cycles denied, granted on cycle MAX_WAIT+1.
- m1 dropping req while waiting clears age; no credit is kept.
- rst during an outstanding read: rvalid is suppressed on the following cycle and the read is lost. Requesters reissue.
- rst held high: no grants, even with req=1.

## Structure
- Package yd_pkg: typedef master_id_e {M_CPU=0, M_DBG=1}; localparam AGE_W=4.
- One sub-module, ram_arb_age: the saturating age counter with force output (age == MAX_WAIT). The top holds the grant mux and the read-return register.

## Test plan
- Solo read: m0 read addr 0x05 with RAM[5]=0xFA1C → m0_gnt same cycle, ram_en=1, ram_we=0; next cycle m0_rvalid=1, m0_rdata=0xFA1C, m1_rdata=0.
- Solo write: m1 write addr 0x7F data 0x1234 → m1_gnt=1, ram_we=1, ram_addr=0x7F, ram_wdata=0x1234; no rvalid; readback via m0 returns 0x1234.
- Contention / bounded wait: m0 and m1 request continuously with MAX_WAIT=4 → m0 granted cycles 1–4, m1 granted cycle 5, age back to 0, pattern repeats 4:1.
- Back-to-back reads: m0 reads 0x00, 0x01, 0x02 on consecutive cycles → three grants and three rvalid pulses, each one cycle later with the matching data, no bubbles.
- m1 withdraws: m1 denied 3 cycles, drops req 1 cycle, re-requests → age restarts at 0; m1 waits a full 4 more cycles.
- Reset mid-read: m1 read granted, rst=1 next cycle → m1_rvalid=0, all outputs at reset values; after release, normal grants resume.

Source files
------------

// File: rtl/yd_pkg.sv
// Shared types and constants for the SoC data-RAM arbiter.
package yd_pkg;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DBG = 1'b1
  } master_id_e;

  localparam int AGE_W = 4;

endpackage

// File: rtl/ram_arb_age.sv
// Saturating count of consecutive cycles the debug master was refused;
// force_o tells the grant logic to let it through ahead of the core.
module ram_arb_age
  import yd_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic gnt_i,
  output logic force_o
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0] age_q, age_d;

  // A withdrawn request forfeits any accumulated credit.
  always_comb begin
    age_d = '0;
    if (req_i && !gnt_i) begin
      age_d = (age_q == AGE_MAX) ? AGE_MAX : age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign force_o = (age_q == AGE_MAX);

endmodule

// File: rtl/ram_arb.sv
// Two-master arbiter for the single-port data RAM: core has fixed priority,
// the debug/loader port is guaranteed a slot after MAX_WAIT refusals.
module ram_arb
  import yd_pkg::*;
#(
  parameter int DW       = 16,
  parameter int RAM_AW   = 7,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [RAM_AW-1:0] m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [RAM_AW-1:0] m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DW-1:0]     m0_rdata,
  output logic [DW-1:0]     m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);

  logic       force_m1;
  logic       rd_pend_q, rd_pend_d;
  master_id_e rd_owner_q, rd_owner_d;

  ram_arb_age #(
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .clk    (clk),
    .rst    (rst),
    .req_i  (m1_req),
    .gnt_i  (m1_gnt),
    .force_o(force_m1)
  );

  // Grants are held off entirely while reset is asserted.
  assign m1_gnt = !rst && m1_req && (!m0_req || force_m1);
  assign m0_gnt = !rst && m0_req && !m1_gnt;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (m0_gnt) begin
      ram_en    = 1'b1;
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_en    = 1'b1;
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  always_comb begin
    rd_pend_d  = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
    rd_owner_d = rd_owner_q;
    if (m0_gnt) begin
      rd_owner_d = M_CPU;
    end else if (m1_gnt) begin
      rd_owner_d = M_DBG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= M_CPU;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // A read outstanding when reset arrives is dropped, not returned late.
  assign m0_rvalid = rd_pend_q && !rst && (rd_owner_q == M_CPU);
  assign m1_rvalid = rd_pend_q && !rst && (rd_owner_q == M_DBG);
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule
